frame_pingpong_buf: RTL and testbench

Parametrised, double-buffered frame register file that generalises the fixed 4x4 x 32-bit half-frame store. Column groups of a ROWS x COLS frame arrive over a valid/ready write port in any order. A frame is released whole to the consumer only once every group has been written. While the consumer drains one bank, the producer fills the other. The block sits between the column-wise round/transform datapath and the frame consumer, replacing ad-hoc write-select muxing with a handshake-safe buffer.

---
 rtl/frame_pingpong_buf.sv | 136 +++++++++++++
 tb/tb_frame_pingpong_buf.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_pingpong_buf.sv
// frame_pingpong_buf: double-buffered ROWS x COLS frame store.
// A producer writes GRP-column groups of a frame in any order over a valid/ready
// port into the write bank. Once every group has been written, that bank is
// marked full and is presented whole to the consumer. The producer meanwhile
// fills the other bank.
//
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   wr_valid_i     write beat present
//   wr_ready_o     write beat can be accepted
//   wr_grp_i       column-group index of the beat
//   wr_data_i      ROWS x GRP words; word (r,j) at [(r*GRP+j)*WIDTH +: WIDTH]
//   rd_valid_o     complete frame available
//   rd_ready_i     consumer takes the frame
//   rd_frame_o     ROWS x COLS words; word (r,c) at [(r*COLS+c)*WIDTH +: WIDTH]
//   grp_err_o      sticky; set when a beat with an out-of-range group is accepted
//   frame_cnt_o    frames delivered, wrapping 16-bit count
module frame_pingpong_buf #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned GRP   = 2,
  localparam int unsigned NGRP = COLS / GRP,
  localparam int unsigned GW   = (NGRP > 1) ? $clog2(NGRP) : 1,
  localparam int unsigned DW   = ROWS * GRP * WIDTH,
  localparam int unsigned FW   = ROWS * COLS * WIDTH
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          wr_valid_i,
  output logic          wr_ready_o,
  input  logic [GW-1:0] wr_grp_i,
  input  logic [DW-1:0] wr_data_i,
  output logic          rd_valid_o,
  input  logic          rd_ready_i,
  output logic [FW-1:0] rd_frame_o,
  output logic          grp_err_o,
  output logic [15:0]   frame_cnt_o
);

  logic [FW-1:0]   bank_q [2];
  logic [FW-1:0]   bank_d [2];
  logic [1:0]      full_q, full_d;
  logic            wp_q, wp_d;
  logic            rp_q, rp_d;
  logic [NGRP-1:0] mask_q, mask_d;
  logic            grp_err_q, grp_err_d;
  logic [15:0]     frame_cnt_q, frame_cnt_d;

  logic            grp_ok;
  logic            wr_fire;
  logic            rd_fire;
  logic [NGRP-1:0] grp_bit;
  logic [NGRP-1:0] mask_set;
  logic            complete;

  // When NGRP is a power of two every encodable index is legal.
  if ((2 ** GW) == NGRP) begin : g_grp_all_ok
    assign grp_ok = 1'b1;
  end else begin : g_grp_range
    assign grp_ok = (wr_grp_i < GW'(NGRP));
  end

  assign wr_ready_o  = ~full_q[wp_q];
  assign rd_valid_o  = full_q[rp_q];
  assign rd_frame_o  = bank_q[rp_q];
  assign grp_err_o   = grp_err_q;
  assign frame_cnt_o = frame_cnt_q;

  assign wr_fire  = wr_valid_i & wr_ready_o;
  assign rd_fire  = rd_valid_o & rd_ready_i;
  assign grp_bit  = NGRP'(1) << wr_grp_i;
  assign mask_set = mask_q | grp_bit;
  assign complete = wr_fire & grp_ok & (&mask_set);

  always_comb begin
    int unsigned g;
    bank_d      = bank_q;
    full_d      = full_q;
    wp_d        = wp_q;
    rp_d        = rp_q;
    mask_d      = mask_q;
    grp_err_d   = grp_err_q;
    frame_cnt_d = frame_cnt_q;
    g           = 32'(wr_grp_i);

    if (wr_fire) begin
      if (grp_ok) begin
        for (int unsigned r = 0; r < ROWS; r++) begin
          for (int unsigned j = 0; j < GRP; j++) begin
            bank_d[wp_q][(r * COLS + g * GRP + j) * WIDTH +: WIDTH] =
                wr_data_i[(r * GRP + j) * WIDTH +: WIDTH];
          end
        end
        mask_d = mask_set;
      end else begin
        grp_err_d = 1'b1;
      end
    end

    // Completion and read always target different banks, so both can apply.
    if (complete) begin
      full_d[wp_q] = 1'b1;
      mask_d       = '0;
      wp_d         = ~wp_q;
    end
    if (rd_fire) begin
      full_d[rp_q] = 1'b0;
      rp_d         = ~rp_q;
      frame_cnt_d  = frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bank_q[0]   <= '0;
      bank_q[1]   <= '0;
      full_q      <= '0;
      wp_q        <= 1'b0;
      rp_q        <= 1'b0;
      mask_q      <= '0;
      grp_err_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      bank_q[0]   <= bank_d[0];
      bank_q[1]   <= bank_d[1];
      full_q      <= full_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      mask_q      <= mask_d;
      grp_err_q   <= grp_err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_frame_pingpong_buf.sv
`timescale 1ns/1ps
module tb_frame_pingpong_buf;
  localparam int W   = 32;
  localparam int R   = 4;
  localparam int C   = 4;
  localparam int G   = 2;
  localparam int NG  = 2;
  localparam int GW  = 1;
  localparam int FW  = R * C * W;
  localparam int DW  = R * G * W;
  localparam int C6  = 6;
  localparam int GW6 = 2;
  localparam int FW6 = R * C6 * W;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          wr_valid, wr_ready, rd_valid, rd_ready, grp_err;
  logic [GW-1:0] wr_grp;
  logic [DW-1:0] wr_data;
  logic [FW-1:0] rd_frame;
  logic [15:0]   frame_cnt;

  logic           wr_valid6, wr_ready6, rd_valid6, rd_ready6, grp_err6;
  logic [GW6-1:0] wr_grp6;
  logic [DW-1:0]  wr_data6;
  logic [FW6-1:0] rd_frame6;
  logic [15:0]    frame_cnt6;

  frame_pingpong_buf dut (
    .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready),
    .wr_grp_i(wr_grp), .wr_data_i(wr_data), .rd_valid_o(rd_valid), .rd_ready_i(rd_ready),
    .rd_frame_o(rd_frame), .grp_err_o(grp_err), .frame_cnt_o(frame_cnt)
  );

  frame_pingpong_buf #(.WIDTH(W), .ROWS(R), .COLS(C6), .GRP(G)) dut6 (
    .clk_i(clk), .rst_ni(rst_n), .wr_valid_i(wr_valid6), .wr_ready_o(wr_ready6),
    .wr_grp_i(wr_grp6), .wr_data_i(wr_data6), .rd_valid_o(rd_valid6), .rd_ready_i(rd_ready6),
    .rd_frame_o(rd_frame6), .grp_err_o(grp_err6), .frame_cnt_o(frame_cnt6)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model of the bank being filled plus the scoreboard of completed frames.
  logic [W-1:0]  mdl [R*C];
  logic [NG-1:0] mmask;
  logic [FW-1:0] exp_q [$];

  function automatic logic [DW-1:0] mk_data(input logic [31:0] base);
    logic [DW-1:0] d;
    for (int k = 0; k < R * G; k++) d[k*W +: W] = base + 32'(k);
    return d;
  endfunction

  function automatic logic [W-1:0] word_of(input logic [FW-1:0] f, input int r, input int c);
    return f[(r*C + c)*W +: W];
  endfunction

  function automatic void mdl_clear();
    for (int i = 0; i < R * C; i++) mdl[i] = '0;
    mmask = '0;
    exp_q.delete();
  endfunction

  function automatic void mdl_write(input int g, input logic [DW-1:0] d);
    logic [FW-1:0] f;
    for (int r = 0; r < R; r++)
      for (int j = 0; j < G; j++) mdl[r*C + g*G + j] = d[(r*G + j)*W +: W];
    mmask[g] = 1'b1;
    if (&mmask) begin
      for (int i = 0; i < R * C; i++) f[i*W +: W] = mdl[i];
      exp_q.push_back(f);
      mmask = '0;
    end
  endfunction

  function automatic logic [FW-1:0] pop_exp();
    if (exp_q.size() == 0) return 'x;
    return exp_q.pop_front();
  endfunction

  // Drive one beat, waiting (bounded) for wr_ready. Entered and left just after a posedge.
  task automatic drive_beat(input int g, input logic [DW-1:0] d);
    bit ok = 1'b0;
    wr_valid = 1'b1;
    wr_grp   = GW'(g);
    wr_data  = d;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wr_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL beat_timeout: wr_ready got %b required 1 within 50 cycles", wr_ready);
    end
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    if (ok) mdl_write(g, d);
  endtask

  task automatic take_frame();
    rd_ready = 1'b1;
    @(posedge clk);
    #1;
    rd_ready = 1'b0;
  endtask

  task automatic apply_reset();
    wr_valid = 1'b0; rd_ready = 1'b0; wr_valid6 = 1'b0; rd_ready6 = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mdl_clear();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_wr_ready: got %b required 1", wr_ready); end
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid: got %b required 0", rd_valid); end
    n_chk++; if (rd_frame !== '0) begin n_fail++; $display("FAIL rst_rd_frame: got %h required 0", rd_frame); end
    n_chk++; if (grp_err !== 1'b0) begin n_fail++; $display("FAIL rst_grp_err: got %b required 0", grp_err); end
    n_chk++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_frame_cnt: got %0d required 0", frame_cnt); end
    n_chk++; if (rd_valid6 !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid6: got %b required 0", rd_valid6); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mdl_clear();
  endtask

  task automatic test_basic();
    logic [FW-1:0] e;
    apply_reset();
    drive_beat(0, {8{32'h11111111}});
    @(negedge clk);
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early: rd_valid got %b required 0", rd_valid); end
    @(posedge clk); #1;
    drive_beat(1, {8{32'h22222222}});
    @(negedge clk);
    n_chk++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: rd_valid got %b required 1", rd_valid); end
    e = pop_exp();
    n_chk++; if (rd_frame !== e) begin n_fail++; $display("FAIL basic_frame: got %h required %h", rd_frame, e); end
    n_chk++; if (word_of(rd_frame, 3, 1) !== 32'h11111111) begin n_fail++; $display("FAIL basic_col1: got %h required 11111111", word_of(rd_frame, 3, 1)); end
    n_chk++; if (word_of(rd_frame, 2, 2) !== 32'h22222222) begin n_fail++; $display("FAIL basic_col2: got %h required 22222222", word_of(rd_frame, 2, 2)); end
    n_chk++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL basic_cnt0: got %0d required 0", frame_cnt); end
    @(negedge clk);
    n_chk++; if (rd_valid !== 1'b1 || rd_frame !== e) begin n_fail++; $display("FAIL basic_hold: valid %b frame %h required 1 / %h", rd_valid, rd_frame, e); end
    @(posedge clk); #1;
    take_frame();
    @(negedge clk);
    n_chk++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL basic_cnt1: got %0d required 1", frame_cnt); end
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL basic_released: rd_valid got %b required 0", rd_valid); end
    @(posedge clk); #1;
  endtask

  task automatic test_out_of_order();
    logic [FW-1:0] e;
    apply_reset();
    drive_beat(1, mk_data(32'hA000));
    @(negedge clk);
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_early1: rd_valid got %b required 0", rd_valid); end
    @(posedge clk); #1;
    drive_beat(1, mk_data(32'hB000));
    @(negedge clk);
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL ooo_early2: rd_valid got %b required 0", rd_valid); end
    @(posedge clk); #1;
    drive_beat(0, mk_data(32'hC000));
    @(negedge clk);
    n_chk++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL ooo_valid: rd_valid got %b required 1", rd_valid); end
    e = pop_exp();
    n_chk++; if (rd_frame !== e) begin n_fail++; $display("FAIL ooo_frame: got %h required %h", rd_frame, e); end
    // Word (1,3) is B-beat word r*GRP+j = 3; word (2,0) is C-beat word 4.
    n_chk++; if (word_of(rd_frame, 1, 3) !== 32'hB003) begin n_fail++; $display("FAIL ooo_overwrite: got %h required 0000b003", word_of(rd_frame, 1, 3)); end
    n_chk++; if (word_of(rd_frame, 2, 0) !== 32'hC004) begin n_fail++; $display("FAIL ooo_col0: got %h required 0000c004", word_of(rd_frame, 2, 0)); end
    @(posedge clk); #1;
    take_frame();
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] e;
    apply_reset();
    drive_beat(0, mk_data(32'h100)); drive_beat(1, mk_data(32'h108));
    drive_beat(0, mk_data(32'h200)); drive_beat(1, mk_data(32'h208));
    @(negedge clk);
    n_chk++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: wr_ready got %b required 0", wr_ready); end
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_grp = 1'b0; wr_data = mk_data(32'h300);
    repeat (3) begin
      @(negedge clk);
      n_chk++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall: wr_ready got %b required 0", wr_ready); end
    end
    e = pop_exp();
    n_chk++; if (rd_frame !== e) begin n_fail++; $display("FAIL bp_first: got %h required %h", rd_frame, e); end
    @(posedge clk); #1;
    take_frame();
    @(negedge clk);
    n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL bp_freed: wr_ready got %b required 1", wr_ready); end
    n_chk++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL bp_cnt1: got %0d required 1", frame_cnt); end
    n_chk++; if (rd_valid !== 1'b1 || rd_frame !== exp_q[0]) begin n_fail++; $display("FAIL bp_second: valid %b frame %h required 1 / %h", rd_valid, rd_frame, exp_q[0]); end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    mdl_write(0, mk_data(32'h300));
    drive_beat(1, mk_data(32'h308));
    @(negedge clk);
    n_chk++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL bp_refull: wr_ready got %b required 0", wr_ready); end
    e = pop_exp();
    n_chk++; if (rd_frame !== e) begin n_fail++; $display("FAIL bp_second_data: got %h required %h", rd_frame, e); end
    @(posedge clk); #1;
    take_frame();
    @(negedge clk);
    e = pop_exp();
    n_chk++; if (rd_frame !== e) begin n_fail++; $display("FAIL bp_third: got %h required %h", rd_frame, e); end
    @(posedge clk); #1;
    take_frame();
    @(negedge clk);
    n_chk++; if (frame_cnt !== 16'd3) begin n_fail++; $display("FAIL bp_cnt3: got %0d required 3", frame_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_streaming();
    int got;
    logic [FW-1:0] e;
    apply_reset();
    rd_ready = 1'b1;
    got = 0;
    fork
      begin
        for (int f = 0; f < 8; f++) begin
          for (int g = 0; g < 2; g++) begin
            wr_valid = 1'b1; wr_grp = GW'(g); wr_data = mk_data(32'h1000 + 32'(f*16 + g*8));
            @(negedge clk);
            n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready: wr_ready got %b required 1", wr_ready); end
            @(posedge clk); #1;
            mdl_write(g, mk_data(32'h1000 + 32'(f*16 + g*8)));
          end
        end
        wr_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 100 && got < 8; i++) begin
          @(negedge clk);
          if (rd_valid === 1'b1) begin
            e = pop_exp();
            n_chk++; if (rd_frame !== e) begin n_fail++; $display("FAIL stream_frame%0d: got %h required %h", got, rd_frame, e); end
            got++;
          end
        end
        n_chk++; if (got != 8) begin n_fail++; $display("FAIL stream_count: got %0d frames required 8", got); end
      end
    join
    @(posedge clk);
    @(negedge clk);
    n_chk++; if (frame_cnt !== 16'd8) begin n_fail++; $display("FAIL stream_cnt: got %0d required 8", frame_cnt); end
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL stream_drained: rd_valid got %b required 0", rd_valid); end
    @(posedge clk); #1;
    rd_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    logic [FW-1:0] e;
    apply_reset();
    drive_beat(0, mk_data(32'h400)); drive_beat(1, mk_data(32'h408));
    take_frame();
    e = pop_exp();
    drive_beat(0, mk_data(32'h500)); drive_beat(1, mk_data(32'h508));
    drive_beat(0, mk_data(32'h600));
    rst_n = 1'b0;
    #2;
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_rd_valid: got %b required 0", rd_valid); end
    n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_wr_ready: got %b required 1", wr_ready); end
    n_chk++; if (rd_frame !== '0) begin n_fail++; $display("FAIL mrst_rd_frame: got %h required 0", rd_frame); end
    n_chk++; if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL mrst_cnt: got %0d required 0", frame_cnt); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    mdl_clear();
    drive_beat(0, mk_data(32'h700));
    @(negedge clk);
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL mrst_partial: rd_valid got %b required 0", rd_valid); end
    @(posedge clk); #1;
    drive_beat(1, mk_data(32'h708));
    @(negedge clk);
    e = pop_exp();
    n_chk++; if (rd_valid !== 1'b1 || rd_frame !== e) begin n_fail++; $display("FAIL mrst_fresh: valid %b frame %h required 1 / %h", rd_valid, rd_frame, e); end
    @(posedge clk); #1;
    take_frame();
    @(negedge clk);
    n_chk++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL mrst_cnt1: got %0d required 1", frame_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_cols6();
    logic [W-1:0] ew;
    bit bad;
    apply_reset();
    n_chk++; if (wr_ready6 !== 1'b1) begin n_fail++; $display("FAIL c6_ready: got %b required 1", wr_ready6); end
    wr_valid6 = 1'b1; wr_grp6 = 2'd3; wr_data6 = mk_data(32'hE0);
    @(posedge clk); #1;
    wr_valid6 = 1'b0;
    @(negedge clk);
    n_chk++; if (grp_err6 !== 1'b1) begin n_fail++; $display("FAIL c6_err: grp_err got %b required 1", grp_err6); end
    n_chk++; if (rd_valid6 !== 1'b0) begin n_fail++; $display("FAIL c6_bad_beat: rd_valid got %b required 0", rd_valid6); end
    for (int g = 0; g < 3; g++) begin
      wr_valid6 = 1'b1; wr_grp6 = GW6'(g); wr_data6 = mk_data(32'h600 + 32'(g*16));
      @(posedge clk); #1;
      wr_valid6 = 1'b0;
      @(negedge clk);
      n_chk++; if (rd_valid6 !== (g == 2)) begin n_fail++; $display("FAIL c6_valid_g%0d: got %b required %b", g, rd_valid6, g == 2); end
    end
    bad = 1'b0;
    for (int r = 0; r < R; r++) begin
      for (int c = 0; c < C6; c++) begin
        ew = 32'h600 + 32'((c / 2) * 16 + r * 2 + (c % 2));
        if (rd_frame6[(r*C6 + c)*W +: W] !== ew) begin
          bad = 1'b1;
          $display("FAIL c6_word_%0d_%0d: got %h required %h", r, c, rd_frame6[(r*C6 + c)*W +: W], ew);
        end
      end
    end
    n_chk++; if (bad) n_fail++;
    n_chk++; if (grp_err6 !== 1'b1) begin n_fail++; $display("FAIL c6_err_sticky: got %b required 1", grp_err6); end
    rd_ready6 = 1'b1;
    @(posedge clk); #1;
    rd_ready6 = 1'b0;
    @(negedge clk);
    n_chk++; if (frame_cnt6 !== 16'd1 || rd_valid6 !== 1'b0) begin n_fail++; $display("FAIL c6_taken: cnt %0d valid %b required 1 / 0", frame_cnt6, rd_valid6); end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wr_valid = 1'b0; wr_grp = '0; wr_data = '0; rd_ready = 1'b0;
    wr_valid6 = 1'b0; wr_grp6 = '0; wr_data6 = '0; rd_ready6 = 1'b0;
    mdl_clear();
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_out_of_order();
    test_backpressure();
    test_streaming();
    test_mid_reset();
    test_cols6();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
